phase_sequencer: RTL

//  Multi-cycle phase sequencer for the 16-bit core. Steps every instruction through P1..P5
//  (fetch, decode, execute, memory, writeback) and starts/stops the core from the EXEC button.

---
 rtl/phase_sequencer_pkg.sv | 43 ++++
 rtl/phase_sequencer_if.sv | 34 +++
 rtl/phase_sequencer_branch_cond_eval.sv | 32 +++
 rtl/phase_sequencer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: state encodings, opcode fields
// and instruction-decode helpers.
package phase_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_STOP = 3'd0,
      ST_P1   = 3'd1,
      ST_P2   = 3'd2,
      ST_P3   = 3'd3,
      ST_P4   = 3'd4,
      ST_P5   = 3'd5,
      ST_HALT = 3'd6
   } seq_state_t;

   localparam logic [1:0] OP_ALU  = 2'b11;
   localparam logic [4:0] OP_B    = 5'b10100;
   localparam logic [4:0] OP_BCC  = 5'b10111;
   localparam logic [3:0] FN_HLT  = 4'b1111;

   localparam logic [2:0] COND_BE  = 3'b000;
   localparam logic [2:0] COND_BLT = 3'b001;
   localparam logic [2:0] COND_BLE = 3'b010;
   localparam logic [2:0] COND_BNE = 3'b011;

   function automatic logic [4:0] phase_onehot(input seq_state_t st);
      logic [4:0] oh;
      case (st)
         ST_P1:   oh = 5'b00001;
         ST_P2:   oh = 5'b00010;
         ST_P3:   oh = 5'b00100;
         ST_P4:   oh = 5'b01000;
         ST_P5:   oh = 5'b10000;
         default: oh = 5'b00000;
      endcase
      return oh;
   endfunction

   // HLT is an ALU-class instruction whose function field is all ones
   function automatic logic is_hlt(input logic [1:0] op, input logic [3:0] fn);
      return (op == OP_ALU) && (fn == FN_HLT);
   endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the core front panel/datapath and the phase sequencer.
// STEP exists only when SINGLE_STEP_EN is defined.
interface phase_sequencer_if;
`ifdef SINGLE_STEP_EN
   logic        STEP;
`endif
   logic        EXEC;
   logic [15:0] COMMAND;
   logic [3:0]  SZCV;
   logic [4:0]  phase;
   logic        running;
   logic        halted;
   logic        ir_load;
   logic        pc_inc;
   logic        pc_load;
   logic        branch_taken;

   modport master (
`ifdef SINGLE_STEP_EN
      output STEP,
`endif
      output EXEC, COMMAND, SZCV,
      input  phase, running, halted, ir_load, pc_inc, pc_load, branch_taken
   );

   modport slave (
`ifdef SINGLE_STEP_EN
      input  STEP,
`endif
      input  EXEC, COMMAND, SZCV,
      output phase, running, halted, ir_load, pc_inc, pc_load, branch_taken
   );

endinterface

// File: rtl/phase_sequencer_branch_cond_eval.sv
// Conditional-branch evaluator: maps the condition code and {S,Z,C,V} flags to taken.
module branch_cond_eval
   import phase_sequencer_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [3:0] szcv,
   output logic       taken
);

   logic s_flag;
   logic z_flag;
   logic v_flag;
   logic unused_c_flag;

   assign s_flag        = szcv[3];
   assign z_flag        = szcv[2];
   assign unused_c_flag = szcv[1];
   assign v_flag        = szcv[0];

   // Condition select
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_BE:  taken = z_flag;
         COND_BLT: taken = s_flag ^ v_flag;
         COND_BLE: taken = z_flag | (s_flag ^ v_flag);
         COND_BNE: taken = ~z_flag;
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer with EXEC run/stop, HLT retirement and branch resolution.
// Optional single-step input enabled by defining SINGLE_STEP_EN.
module phase_sequencer
   import phase_sequencer_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0
)(
   input logic CLOCK,
   input logic RESET,
   phase_sequencer_if.slave bus
);

   localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

   seq_state_t state_r, state_s;
   logic [3:0] wait_cnt_r, wait_cnt_s;
   logic       exec_q_r, exec_rise_s;
   logic       stop_pend_r, stop_pend_s;
   logic       hlt_pend_r, hlt_pend_s;
   logic       branch_taken_r, branch_taken_s;
   logic [4:0] phase_r;
   logic       running_r, halted_r;
   logic       cond_taken_s, taken_s, in_run_s, step_go_s;
   logic       unused_cmd_bits;

   assign exec_rise_s     = bus.EXEC & ~exec_q_r;
   assign in_run_s        = (state_r >= ST_P1) && (state_r <= ST_P5);
   assign unused_cmd_bits = ^bus.COMMAND[3:0];

`ifdef SINGLE_STEP_EN
   logic step_q_r;
   // A simultaneous EXEC rise wins, so a step only counts when EXEC did not rise
   assign step_go_s = (state_r == ST_STOP) & bus.STEP & ~step_q_r & ~exec_rise_s;

   // STEP edge-detect history
   always_ff @(posedge CLOCK) begin
      if (RESET) step_q_r <= 1'b0;
      else       step_q_r <= bus.STEP;
   end
`else
   assign step_go_s = 1'b0;
`endif

   branch_cond_eval u_cond (
      .cond  (bus.COMMAND[10:8]),
      .szcv  (bus.SZCV),
      .taken (cond_taken_s)
   );

   // Opcode-level branch decision
   always_comb begin
      taken_s = 1'b0;
      if (bus.COMMAND[15:11] == OP_B)        taken_s = 1'b1;
      else if (bus.COMMAND[15:11] == OP_BCC) taken_s = cond_taken_s;
      else                                   taken_s = 1'b0;
   end

   // Next-state logic and pending-flag updates
   always_comb begin
      state_s    = state_r;
      wait_cnt_s = wait_cnt_r;
      case (state_r)
         ST_STOP: state_s = (exec_rise_s | step_go_s) ? ST_P1 : ST_STOP;
         ST_P1:   state_s = ST_P2;
         ST_P2:   state_s = ST_P3;
         ST_P3: begin
            state_s    = ST_P4;
            wait_cnt_s = WAIT_INIT;
         end
         ST_P4: begin
            if (wait_cnt_r != 4'd0) begin
               wait_cnt_s = wait_cnt_r - 4'd1;
               state_s    = ST_P4;
            end else begin
               state_s    = ST_P5;
            end
         end
         ST_P5: begin
            if (hlt_pend_r)                       state_s = ST_HALT;
            else if (stop_pend_r | exec_rise_s)   state_s = ST_STOP;
            else                                  state_s = ST_P1;
         end
         ST_HALT: state_s = ST_HALT;
         default: state_s = ST_STOP;
      endcase

      if (state_s == ST_STOP)                        stop_pend_s = 1'b0;
      else if ((in_run_s & exec_rise_s) | step_go_s) stop_pend_s = 1'b1;
      else                                           stop_pend_s = stop_pend_r;

      if (state_s == ST_P1)                          hlt_pend_s = 1'b0;
      else if ((state_r == ST_P2) && is_hlt(bus.COMMAND[15:14], bus.COMMAND[7:4]))
                                                     hlt_pend_s = 1'b1;
      else                                           hlt_pend_s = hlt_pend_r;

      if (state_s == ST_P1)                          branch_taken_s = 1'b0;
      else if (state_r == ST_P3)                     branch_taken_s = taken_s;
      else                                           branch_taken_s = branch_taken_r;
   end

   // State and status registers; status mirrors the state being entered
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_r        <= ST_STOP;
         wait_cnt_r     <= 4'd0;
         exec_q_r       <= 1'b0;
         stop_pend_r    <= 1'b0;
         hlt_pend_r     <= 1'b0;
         branch_taken_r <= 1'b0;
         phase_r        <= 5'b00000;
         running_r      <= 1'b0;
         halted_r       <= 1'b0;
      end else begin
         state_r        <= state_s;
         wait_cnt_r     <= wait_cnt_s;
         exec_q_r       <= bus.EXEC;
         stop_pend_r    <= stop_pend_s;
         hlt_pend_r     <= hlt_pend_s;
         branch_taken_r <= branch_taken_s;
         phase_r        <= phase_onehot(state_s);
         running_r      <= (state_s >= ST_P1) && (state_s <= ST_P5);
         halted_r       <= (state_s == ST_HALT);
      end
   end

   assign bus.phase        = phase_r;
   assign bus.running      = running_r;
   assign bus.halted       = halted_r;
   assign bus.branch_taken = branch_taken_r;
   // Strobes are masked during reset so an aborted instruction emits nothing
   assign bus.ir_load      = (state_r == ST_P1) & ~RESET;
   assign bus.pc_inc       = (state_r == ST_P1) & ~RESET;
   assign bus.pc_load      = (state_r == ST_P5) & branch_taken_r & ~RESET;

endmodule
